// File: rtl/i2s_tx_feeder.sv
// Stereo sample FIFO feeding the I2S transmitter parallel inputs, one L/R pair per LRCK frame.
// Optional I2S_TX_FEEDER_HOLD_EN: repeat the last pair on underflow instead of emitting silence.
module i2s_tx_feeder #(
  parameter int PDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                         mclk_in,
  input  logic                         arstn_in,
  input  logic                         lrck_in,
  input  logic                         s_valid_in,
  output logic                         s_ready_out,
  input  logic [PDATA_WIDTH-1:0]       s_ldata_in,
  input  logic [PDATA_WIDTH-1:0]       s_rdata_in,
  output logic [PDATA_WIDTH-1:0]       pldata_out,
  output logic [PDATA_WIDTH-1:0]       prdata_out,
  output logic [$clog2(FIFO_DEPTH):0]  level_out,
  output logic                         underflow_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [2*PDATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW:0]              level;
  logic                     rdy_q;
  logic                     lrck_d;
  logic                     full;
  logic                     empty;
  logic                     tick;
  logic                     push;
  logic                     pop;

  assign full        = (level == DEPTH_L);
  assign empty       = (level == '0);
  assign s_ready_out = rdy_q & ~full;
  assign push        = s_valid_in & s_ready_out;
  // rdy_q masks the first cycle after release, so a low LRCK against the
  // reset value of lrck_d is not mistaken for a frame start.
  assign tick        = lrck_d & ~lrck_in & rdy_q;
  assign pop         = tick & ~empty;
  assign level_out   = level;

  always_ff @(posedge mclk_in) begin
    if (push) mem[wr_ptr] <= {s_ldata_in, s_rdata_in};
  end

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      rdy_q  <= 1'b0;
      lrck_d <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      rdy_q  <= 1'b1;
      lrck_d <= lrck_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      pldata_out    <= '0;
      prdata_out    <= '0;
      underflow_out <= 1'b0;
    end else begin
      underflow_out <= tick & empty;
      if (pop) begin
        {pldata_out, prdata_out} <= mem[rd_ptr];
      end else if (tick) begin
`ifdef I2S_TX_FEEDER_HOLD_EN
        pldata_out <= pldata_out;
        prdata_out <= prdata_out;
`else
        pldata_out <= '0;
        prdata_out <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Directed bench for i2s_tx_feeder: reset, frame pops, full/empty boundaries, wrap and mid-run reset.
module tb_i2s_tx_feeder;

  logic        mclk = 1'b0;
  logic        arstn;
  logic        lrck;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_ldata;
  logic [31:0] s_rdata;
  logic [31:0] pldata;
  logic [31:0] prdata;
  logic [3:0]  level;
  logic        underflow;

  int errors = 0;
  int checks = 0;
  logic [63:0] q[$];
  logic [31:0] exp_l = '0;
  logic [31:0] exp_r = '0;
  logic        exp_uf;

  i2s_tx_feeder #(.PDATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .mclk_in(mclk), .arstn_in(arstn), .lrck_in(lrck),
    .s_valid_in(s_valid), .s_ready_out(s_ready),
    .s_ldata_in(s_ldata), .s_rdata_in(s_rdata),
    .pldata_out(pldata), .prdata_out(prdata),
    .level_out(level), .underflow_out(underflow)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    s_valid = 1'b1; s_ldata = l; s_rdata = r;
    q.push_back({l, r});
    cyc(1);
    s_valid = 1'b0;
  endtask

  // One frame: LRCK high for two cycles, then falls; optional push on the tick cycle.
  task automatic frame(input string tag, input bit do_push, input logic [31:0] l, input logic [31:0] r);
    lrck = 1'b1;
    cyc(2);
    lrck = 1'b0;
    if (q.size() == 0) begin
      exp_uf = 1'b1;
`ifndef I2S_TX_FEEDER_HOLD_EN
      exp_l = '0; exp_r = '0;
`endif
    end else begin
      exp_uf = 1'b0;
      {exp_l, exp_r} = q.pop_front();
    end
    if (do_push) begin
      s_valid = 1'b1; s_ldata = l; s_rdata = r;
      q.push_back({l, r});
    end
    cyc(1);
    s_valid = 1'b0;
    chk({tag, "_l"}, pldata, exp_l);
    chk({tag, "_r"}, prdata, exp_r);
    chk({tag, "_uf"}, underflow, exp_uf);
    chk({tag, "_lvl"}, level, q.size());
  endtask

  initial begin
    arstn = 1'b0; lrck = 1'b0; s_valid = 1'b0; s_ldata = '0; s_rdata = '0;
    cyc(3);
    chk("rst_l", pldata, 0);
    chk("rst_r", prdata, 0);
    chk("rst_lvl", level, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_rdy", s_ready, 0);

    // Release with LRCK low: no tick, ready one cycle later.
    arstn = 1'b1;
    #1 chk("rel_rdy0", s_ready, 0);
    cyc(1);
    chk("rel_rdy1", s_ready, 1);
    chk("rel_uf0", underflow, 0);
    cyc(1);
    chk("rel_uf1", underflow, 0);
    lrck = 1'b1;
    cyc(3);
    chk("hi_uf", underflow, 0);
    chk("hi_l", pldata, 0);
    lrck = 1'b0;
    cyc(1);
    chk("fall_uf", underflow, 1);
    cyc(1);
    chk("fall_uf_end", underflow, 0);

    // Two pairs over three frames.
    push(32'h11111111, 32'h22222222);
    push(32'h33333333, 32'h44444444);
    chk("two_lvl", level, 2);
    lrck = 1'b1; cyc(2); lrck = 1'b0; cyc(1);
    chk("f1_l", pldata, 32'h11111111);
    chk("f1_r", prdata, 32'h22222222);
    chk("f1_uf", underflow, 0);
    void'(q.pop_front());
    lrck = 1'b1; cyc(2); lrck = 1'b0; cyc(1);
    chk("f2_l", pldata, 32'h33333333);
    chk("f2_r", prdata, 32'h44444444);
    void'(q.pop_front());
    exp_l = 32'h33333333; exp_r = 32'h44444444;
    lrck = 1'b1; cyc(2); lrck = 1'b0; cyc(1);
    chk("f3_uf", underflow, 1);
`ifdef I2S_TX_FEEDER_HOLD_EN
    chk("f3_l", pldata, 32'h33333333);
    chk("f3_r", prdata, 32'h44444444);
`else
    chk("f3_l", pldata, 0);
    chk("f3_r", prdata, 0);
    exp_l = '0; exp_r = '0;
`endif
    cyc(1);
    chk("f3_uf_end", underflow, 0);

    // Fill to full with LRCK held low.
    for (int i = 0; i < 8; i++) push(32'hA0000000 + i, 32'hB0000000 + i);
    chk("full_lvl", level, 8);
    chk("full_rdy", s_ready, 0);
    frame("full_tick", 1'b0, '0, '0);
    chk("full_tick_rdy", s_ready, 1);
    push(32'hC0000000, 32'hD0000000);
    chk("refill_lvl", level, 8);
    for (int i = 0; i < 8; i++) frame("drain", 1'b0, '0, '0);
    chk("drain_lvl", level, 0);

    // Level 3 with coincident push/pop, including pointer wrap.
    for (int i = 0; i < 3; i++) push(32'hE0000000 + i, 32'hF0000000 + i);
    chk("lvl3", level, 3);
    for (int k = 0; k < 20; k++) frame("coinc", 1'b1, 32'h50000000 + k, 32'h60000000 + k);
    for (int i = 0; i < 3; i++) frame("drain2", 1'b0, '0, '0);

    // Empty with a push exactly on the tick cycle.
    frame("empty_push", 1'b1, 32'h55555555, 32'h66666666);
    frame("empty_next", 1'b0, '0, '0);
    chk("empty_next_l", pldata, 32'h55555555);

    // Reset mid-frame at level 5.
    for (int i = 0; i < 5; i++) push(32'h70000000 + i, 32'h80000000 + i);
    chk("pre_rst_lvl", level, 5);
    lrck = 1'b1;
    cyc(1);
    #2 arstn = 1'b0;
    #1;
    chk("mid_rst_l", pldata, 0);
    chk("mid_rst_r", prdata, 0);
    chk("mid_rst_lvl", level, 0);
    chk("mid_rst_rdy", s_ready, 0);
    q.delete();
    exp_l = '0; exp_r = '0;
    cyc(2);
    arstn = 1'b1;
    cyc(2);
    frame("post_rst", 1'b0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
